seg_scan_driver: RTL and testbench

Parametrised, time-multiplexed seven-segment display driver that replaces the fixed 4-digit hex-only display stage behind the CPU data tap. It holds a display value loaded by a strobe and scans DIGITS digits at a programmable refresh rate. It shows either hexadecimal or decimal, converting decimal with a sequential binary-to-BCD engine. It adds leading-zero blanking, per-digit decimal points and an overflow indication.

---
 rtl/seg_pkg.sv | 33 +++
 rtl/bin2bcd_seq.sv | 77 +++++++
 rtl/seg_scan_driver.sv | 141 ++++++++++++++
 tb/tb_seg_scan_driver.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared seven-segment constants and the hex glyph decoder.
// Segment vectors are active-high here; output polarity is applied at the top level.
package seg_pkg;

  localparam logic [6:0] SEG_OFF  = 7'b0000000;
  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam int         DP_BIT   = 7;

  // Bit order is gfedcba: bit0 = a ... bit6 = g.
  function automatic logic [6:0] seg_glyph(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one input bit per cycle.
// done/bcd/ovf are valid combinationally during the last busy cycle so the caller can latch on the falling edge of busy.
module bin2bcd_seq #(
  parameter int DATA_W = 16,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_W-1:0]     din,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  function automatic logic [BCD_W-1:0] add3_all(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] > 4'd4) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  logic              busy_p0;
  logic [CNT_W-1:0]  cnt_p0;
  logic              ovf_p0;
  logic [DATA_W-1:0] bin_p0;
  logic [BCD_W-1:0]  bcd_p0;

  logic [BCD_W-1:0]  bcd_adj;
  logic [BCD_W-1:0]  bcd_nxt;
  logic              carry;
  logic              last;

  // A bit carried out of the top digit means the running prefix already reached 10^DIGITS; it stays sticky.
  assign bcd_adj = add3_all(bcd_p0);
  assign carry   = bcd_adj[BCD_W-1];
  assign bcd_nxt = {bcd_adj[BCD_W-2:0], bin_p0[DATA_W-1]};
  assign last    = (cnt_p0 == CNT_W'(DATA_W-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_p0 <= 1'b0;
      cnt_p0  <= '0;
      ovf_p0  <= 1'b0;
    end else if (start && !busy_p0) begin
      busy_p0 <= 1'b1;
      cnt_p0  <= '0;
      ovf_p0  <= 1'b0;
    end else if (busy_p0) begin
      ovf_p0 <= ovf_p0 | carry;
      if (last) busy_p0 <= 1'b0;
      else      cnt_p0  <= cnt_p0 + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (start && !busy_p0) begin
      bin_p0 <= din;
      bcd_p0 <= '0;
    end else if (busy_p0) begin
      bin_p0 <= {bin_p0[DATA_W-2:0], 1'b0};
      bcd_p0 <= bcd_nxt;
    end
  end

  assign busy = busy_p0;
  assign done = busy_p0 & last;
  assign bcd  = bcd_nxt;
  assign ovf  = ovf_p0 | carry;

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment driver: hex or decimal display, leading-zero blanking,
// per-digit decimal points and a dash pattern when a decimal value does not fit.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  mode,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  blank_lz,
  input  logic                  load,
  output logic                  busy,
  output logic [7:0]            sel,
  output logic [DIGITS-1:0]     choose
);

  localparam int   DATA_W = 4 * DIGITS;
  localparam int   PRE_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int   IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic POL    = (ACTIVE_LOW != 0);

  logic [PRE_W-1:0] pre_cnt;
  logic [IDX_W-1:0] dig_idx;
  logic             pre_tc;

  assign pre_tc = (pre_cnt == PRE_W'(REFRESH_DIV-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      dig_idx <= '0;
    end else if (pre_tc) begin
      pre_cnt <= '0;
      dig_idx <= (dig_idx == IDX_W'(DIGITS-1)) ? '0 : dig_idx + 1'b1;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  logic              load_ok;
  logic              conv_start;
  logic              conv_busy;
  logic              conv_done;
  logic              conv_ovf;
  logic [DATA_W-1:0] conv_bcd;

  assign load_ok    = load & ~conv_busy;
  assign conv_start = load_ok & mode;

  bin2bcd_seq #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (conv_start),
    .din   (value),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd),
    .ovf   (conv_ovf)
  );

  // Display register: hex loads land immediately, decimal results on the last conversion cycle.
  logic [DATA_W-1:0] disp_p0;
  logic              dash_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_p0 <= '0;
      dash_p0 <= 1'b0;
    end else if (load_ok && !mode) begin
      disp_p0 <= value;
      dash_p0 <= 1'b0;
    end else if (conv_done) begin
      disp_p0 <= conv_bcd;
      dash_p0 <= conv_ovf;
    end
  end

  logic [DIGITS-1:0] blank;
  logic              zero_above;
  logic [3:0]        cur_nib;
  logic              cur_blank;
  logic              cur_dp;
  logic [6:0]        cur_seg;
  logic [7:0]        seg8;
  logic [DIGITS-1:0] onehot;

  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (disp_p0[4*i +: 4] == 4'd0);
      blank[i]   = blank_lz & ~dash_p0 & zero_above;
    end

    cur_nib   = '0;
    cur_blank = 1'b0;
    cur_dp    = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_idx == IDX_W'(i)) begin
        cur_nib   = disp_p0[4*i +: 4];
        cur_blank = blank[i];
        cur_dp    = dp[i];
      end
    end

    if (dash_p0)        cur_seg = SEG_DASH;
    else if (cur_blank) cur_seg = SEG_OFF;
    else                cur_seg = seg_glyph(cur_nib);

    seg8         = {1'b0, cur_seg};
    seg8[DP_BIT] = cur_dp;
    onehot       = DIGITS'(1) << dig_idx;
  end

  // Output stage: polarity is the final operation before the pins.
  logic [7:0]        sel_p1;
  logic [DIGITS-1:0] choose_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_p1    <= {8{POL}};
      choose_p1 <= {DIGITS{POL}};
    end else begin
      sel_p1    <= seg8 ^ {8{POL}};
      choose_p1 <= onehot ^ {DIGITS{POL}};
    end
  end

  assign busy   = conv_busy;
  assign sel    = sel_p1;
  assign choose = choose_p1;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: a display model pushes the expected glyph per digit,
// and the scan monitor pops and compares each one when that digit is selected.
module tb_seg_scan_driver;

  localparam int DIGITS      = 4;
  localparam int REFRESH_DIV = 4;
  localparam int ACTIVE_LOW  = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic        mode = 1'b0;
  logic [3:0]  dp = '0;
  logic        blank_lz = 1'b0;
  logic        load = 1'b0;
  logic        busy;
  logic [7:0]  sel;
  logic [3:0]  choose;

  seg_scan_driver #(
    .DIGITS      (DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .ACTIVE_LOW  (ACTIVE_LOW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .value    (value),
    .mode     (mode),
    .dp       (dp),
    .blank_lz (blank_lz),
    .load     (load),
    .busy     (busy),
    .sel      (sel),
    .choose   (choose)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         digit;
    logic [7:0] sel;
  } exp_t;

  exp_t sb[$];

  localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Expected active-low pin pattern for every digit of a freshly loaded value.
  task automatic push_display(input logic [15:0] v, input logic dec);
    logic [3:0] d [4];
    logic [6:0] seg;
    logic       dash;
    int         msd;
    exp_t       e;
    dash = dec && (v >= 16'd10000);
    for (int i = 0; i < 4; i++)
      d[i] = dec ? 4'((int'(v) / (10 ** i)) % 10) : v[4*i +: 4];
    msd = 0;
    for (int i = 0; i < 4; i++) if (d[i] != 4'd0) msd = i;
    for (int i = 0; i < 4; i++) begin
      if (dash)                     seg = 7'h40;
      else if (blank_lz && i > msd) seg = 7'h00;
      else                          seg = GLYPH[d[i]];
      e.digit = i;
      e.sel   = ~{dp[i], seg};
      sb.push_back(e);
    end
  endtask

  task automatic drain(input string name);
    exp_t       e;
    logic [3:0] want;
    bit         seen;
    while (sb.size() > 0) begin
      e    = sb.pop_front();
      want = ~(4'b0001 << e.digit);
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
        @(negedge clk);
        if (choose === want) seen = 1'b1;
      end
      n_checks++;
      if (!seen) begin
        n_fail++;
        $display("FAIL %s digit%0d: choose stuck at %h, required %h", name, e.digit, choose, want);
      end else if (sel !== e.sel) begin
        n_fail++;
        $display("FAIL %s digit%0d: sel=%h required %h", name, e.digit, sel, e.sel);
      end
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic m);
    @(negedge clk);
    value = v;
    mode  = m;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int c = 0; c < 100; c++) begin
      if (busy !== 1'b1) break;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    dp = '0;
    blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (7) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (sel !== 8'hFF) begin n_fail++; $display("FAIL reset_sel: sel=%h required ff", sel); end
    n_checks++;
    if (choose !== 4'hF) begin n_fail++; $display("FAIL reset_choose: choose=%h required f", choose); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: busy=%b required 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (choose !== 4'hE) begin n_fail++; $display("FAIL release_choose: choose=%h required e", choose); end
    n_checks++;
    if (sel !== 8'hC0) begin n_fail++; $display("FAIL release_sel: sel=%h required c0", sel); end
  endtask

  task automatic test_hex_scan();
    logic [3:0] want [4];
    logic [3:0] prev;
    bit         found;
    bit         bad;
    want[0] = 4'hE; want[1] = 4'hD; want[2] = 4'hB; want[3] = 4'h7;
    do_load(16'h1A3F, 1'b0);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL hex_busy: busy=%b required 0", busy); end
    push_display(16'h1A3F, 1'b0);
    drain("hex_1a3f");
    prev  = choose;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (choose === 4'hE && prev !== 4'hE) found = 1'b1;
      else prev = choose;
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL scan_align: choose=%h never wrapped to e", choose); end
    for (int k = 0; k < 4; k++) begin
      bad = 1'b0;
      for (int c = 0; c < REFRESH_DIV; c++) begin
        if (choose !== want[k]) bad = 1'b1;
        @(negedge clk);
      end
      n_checks++;
      if (bad) begin n_fail++; $display("FAIL scan_hold%0d: choose=%h required %h for 4 cycles", k, choose, want[k]); end
    end
  endtask

  task automatic test_decimal();
    int n;
    do_load(16'd1234, 1'b1);
    push_display(16'd1234, 1'b1);
    count_busy(n);
    n_checks++;
    if (n != 16) begin n_fail++; $display("FAIL dec_busy_len: busy cycles=%0d required 16", n); end
    drain("dec_1234");
  endtask

  task automatic test_overflow();
    int n;
    do_load(16'd10000, 1'b1);
    push_display(16'd10000, 1'b1);
    count_busy(n);
    n_checks++;
    if (n != 16) begin n_fail++; $display("FAIL ovf_busy_len: busy cycles=%0d required 16", n); end
    drain("dec_ovf");
  endtask

  task automatic test_blank();
    dp = 4'b0100;
    blank_lz = 1'b1;
    do_load(16'h0007, 1'b0);
    push_display(16'h0007, 1'b0);
    drain("blank_lz");
    dp = '0;
    blank_lz = 1'b0;
  endtask

  task automatic test_busy_drop_reset();
    int n;
    int highs;
    do_load(16'd9999, 1'b1);
    push_display(16'd9999, 1'b1);
    n = 0;
    for (int c = 0; c < 100; c++) begin
      if (busy !== 1'b1) break;
      n++;
      if (n == 5) begin
        value = 16'h2222;
        mode  = 1'b0;
        load  = 1'b1;
      end else begin
        load  = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
    n_checks++;
    if (n != 16) begin n_fail++; $display("FAIL drop_busy_len: busy cycles=%0d required 16", n); end
    drain("drop_9999");

    do_load(16'd4321, 1'b1);
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midconv_busy: busy=%b required 0", busy); end
    n_checks++;
    if (sel !== 8'hFF) begin n_fail++; $display("FAIL midconv_sel: sel=%h required ff", sel); end
    n_checks++;
    if (choose !== 4'hF) begin n_fail++; $display("FAIL midconv_choose: choose=%h required f", choose); end
    @(negedge clk);
    rst_n = 1'b1;
    highs = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy !== 1'b0) highs++;
    end
    n_checks++;
    if (highs != 0) begin n_fail++; $display("FAIL midconv_resume: busy high %0d cycles required 0", highs); end
    push_display(16'd0, 1'b0);
    drain("post_reset");
  endtask

  task automatic test_back_to_back();
    int  n;
    bit  idle;
    blank_lz = 1'b1;
    do_load(16'd42, 1'b1);
    idle = 1'b0;
    for (int c = 0; c < 100 && !idle; c++) begin
      if (busy === 1'b0) idle = 1'b1;
      else @(negedge clk);
    end
    value = 16'd567;
    mode  = 1'b1;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: busy=%b required 1", busy); end
    push_display(16'd567, 1'b1);
    count_busy(n);
    n_checks++;
    if (n != 16) begin n_fail++; $display("FAIL b2b_busy_len: busy cycles=%0d required 16", n); end
    drain("b2b_567");
    blank_lz = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_hex_scan();
    test_decimal();
    test_overflow();
    test_blank();
    test_busy_drop_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
